// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Holds the FSM state encoding, the conversion widths and the double-dabble digit adjust.
package disp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StShow
    } state_e;

    localparam int unsigned VAL_W       = 10;
    localparam int unsigned BCD_DIGITS  = 3;
    localparam int unsigned CONV_CYCLES = 10;

    typedef logic [3:0] bcd_digit_t;

    // Digits of 5 or more would carry past 9 after the next left shift.
    function automatic bcd_digit_t add3_adjust(input bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the winner is the first active request
// at or after (ptr + 1) mod NREQ. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IdxW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % NREQ);
            if (!found && enable_i && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/disp_sched_ctrl.sv
// Display scheduler: round-robin grants one requester, converts its 10-bit
// two's-complement operand to sign + 3 BCD digits serially, then dwells.
module disp_sched_ctrl #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DWELL = 1000,
    localparam int unsigned IdxW = $clog2(NREQ)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ*10-1:0] data_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic             busy_o,
    output logic             neg_o,
    output logic [3:0]       bcd_hund_o,
    output logic [3:0]       bcd_tens_o,
    output logic [3:0]       bcd_ones_o,
    output logic [IdxW-1:0]  src_o,
    output logic             disp_valid_o
);

    import disp_pkg::*;

    localparam int unsigned DwellCyc = (DWELL == 0) ? 1 : DWELL;
    localparam int unsigned DwW      = $clog2(DwellCyc + 1);
    localparam int unsigned BcdW     = 4 * BCD_DIGITS;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [IdxW-1:0]    win_q, win_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [VAL_W-1:0]   mag_q, mag_d;
    logic [BcdW-1:0]    bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic [DwW-1:0]     dwell_q, dwell_d;

    logic               neg_q, neg_d;
    logic [3:0]         hund_q, hund_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic [IdxW-1:0]    src_q, src_d;
    logic               valid_q, valid_d;

    logic               arb_en;
    logic [NREQ-1:0]    arb_gnt;
    logic [IdxW-1:0]    arb_idx;
    logic [VAL_W-1:0]   ops [NREQ];
    logic [VAL_W-1:0]   op_sel;
    logic [BcdW-1:0]    bcd_adj;

    // Gated by Resetn so no grant escapes while reset is held.
    assign arb_en = (state_q == StIdle) && Resetn;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .enable_i (arb_en),
        .gnt_o    (arb_gnt),
        .idx_o    (arb_idx)
    );

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            ops[i] = data_i[i*VAL_W +: VAL_W];
        end
        op_sel = ops[arb_idx];
    end

    always_comb begin
        for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            bcd_adj[4*d +: 4] = add3_adjust(bcd_q[4*d +: 4]);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        dwell_d = dwell_q;
        neg_d   = neg_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        src_d   = src_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                if (|arb_gnt) begin
                    ptr_d   = arb_idx;
                    win_d   = arb_idx;
                    sign_d  = op_sel[VAL_W-1];
                    // -512 wraps to 10'h200, which is the correct unsigned magnitude.
                    mag_d   = op_sel[VAL_W-1] ? (~op_sel + 1'b1) : op_sel;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StConvert;
                end
            end
            StConvert: begin
                bcd_d = {bcd_adj[BcdW-2:0], mag_q[VAL_W-1]};
                mag_d = {mag_q[VAL_W-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(CONV_CYCLES - 1)) begin
                    hund_d  = bcd_d[11:8];
                    tens_d  = bcd_d[7:4];
                    ones_d  = bcd_d[3:0];
                    neg_d   = sign_q;
                    src_d   = win_q;
                    valid_d = 1'b1;
                    dwell_d = DwW'(DwellCyc - 1);
                    state_d = StShow;
                end
            end
            StShow: begin
                if (dwell_q == '0) begin
                    state_d = StIdle;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            ptr_q   <= IdxW'(NREQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            dwell_q <= '0;
            neg_q   <= 1'b0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            dwell_q <= dwell_d;
            neg_q   <= neg_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign gnt_o        = arb_gnt;
    assign busy_o       = (state_q != StIdle);
    assign neg_o        = neg_q;
    assign bcd_hund_o   = hund_q;
    assign bcd_tens_o   = tens_q;
    assign bcd_ones_o   = ones_q;
    assign src_o        = src_q;
    assign disp_valid_o = valid_q;

endmodule

// File: tb/tb_disp_sched_ctrl.sv
// Bench for disp_sched_ctrl: two instances (DWELL=4 and DWELL=0) share stimulus
// and are compared every cycle against a timeline-based reference model.
module tb_disp_sched_ctrl;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [39:0] data;

    logic [3:0]  gnt   [2];
    logic        busy  [2];
    logic        neg   [2];
    logic        valid [2];
    logic [3:0]  hund  [2];
    logic [3:0]  tens  [2];
    logic [3:0]  ones  [2];
    logic [1:0]  src   [2];

    always #5 clk = ~clk;

    disp_sched_ctrl #(.NREQ(4), .DWELL(4)) u_dut_d4 (
        .Clock(clk), .Resetn(rst_n), .req_i(req), .data_i(data),
        .gnt_o(gnt[0]), .busy_o(busy[0]), .neg_o(neg[0]),
        .bcd_hund_o(hund[0]), .bcd_tens_o(tens[0]), .bcd_ones_o(ones[0]),
        .src_o(src[0]), .disp_valid_o(valid[0])
    );

    disp_sched_ctrl #(.NREQ(4), .DWELL(0)) u_dut_d0 (
        .Clock(clk), .Resetn(rst_n), .req_i(req), .data_i(data),
        .gnt_o(gnt[1]), .busy_o(busy[1]), .neg_o(neg[1]),
        .bcd_hund_o(hund[1]), .bcd_tens_o(tens[1]), .bcd_ones_o(ones[1]),
        .src_o(src[1]), .disp_valid_o(valid[1])
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: grant time, visibility time and next-free time per instance.
    int dwell_of [2] = '{4, 0};
    int m_free   [2];
    int m_ptr    [2];
    int m_pend_at[2];
    int m_pend_v [2];
    int m_pend_s [2];
    bit m_pend   [2];
    bit s_valid  [2];
    bit s_neg    [2];
    int s_h [2], s_t [2], s_o [2], s_src [2];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_free[k]  = 0;
            m_ptr[k]   = NREQ - 1;
            m_pend[k]  = 1'b0;
            s_valid[k] = 1'b0;
            s_neg[k]   = 1'b0;
            s_h[k] = 0; s_t[k] = 0; s_o[k] = 0; s_src[k] = 0;
        end
    endtask

    task automatic check_dut(input int k, input int exp_gnt, input int exp_busy);
        check_eq($sformatf("d%0d_gnt", k),   int'(gnt[k]),   exp_gnt);
        check_eq($sformatf("d%0d_busy", k),  int'(busy[k]),  exp_busy);
        check_eq($sformatf("d%0d_neg", k),   int'(neg[k]),   int'(s_neg[k]));
        check_eq($sformatf("d%0d_hund", k),  int'(hund[k]),  s_h[k]);
        check_eq($sformatf("d%0d_tens", k),  int'(tens[k]),  s_t[k]);
        check_eq($sformatf("d%0d_ones", k),  int'(ones[k]),  s_o[k]);
        check_eq($sformatf("d%0d_src", k),   int'(src[k]),   s_src[k]);
        check_eq($sformatf("d%0d_valid", k), int'(valid[k]), int'(s_valid[k]));
    endtask

    task automatic step(input logic [3:0] r, input logic [39:0] d);
        int          w;
        int          v;
        int          a;
        int          eg;
        int          eb;
        bit          found;
        logic [9:0]  op;
        @(negedge clk);
        req  = r;
        data = d;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (m_pend[k] && cyc >= m_pend_at[k]) begin
                v          = m_pend_v[k];
                a          = (v < 0) ? -v : v;
                s_valid[k] = 1'b1;
                s_neg[k]   = (v < 0);
                s_h[k]     = a / 100;
                s_t[k]     = (a / 10) % 10;
                s_o[k]     = a % 10;
                s_src[k]   = m_pend_s[k];
                m_pend[k]  = 1'b0;
            end
            eb = (cyc < m_free[k]) ? 1 : 0;
            eg = 0;
            if (cyc >= m_free[k] && r != 4'b0) begin
                found = 1'b0;
                w     = 0;
                for (int j = 1; j <= NREQ; j++) begin
                    if (!found && r[(m_ptr[k] + j) % NREQ]) begin
                        found = 1'b1;
                        w     = (m_ptr[k] + j) % NREQ;
                    end
                end
                eg           = 1 << w;
                m_ptr[k]     = w;
                op           = d[w*10 +: 10];
                m_pend_v[k]  = int'($signed(op));
                m_pend_s[k]  = w;
                m_pend_at[k] = cyc + 11;
                m_pend[k]    = 1'b1;
                m_free[k]    = cyc + 11 + ((dwell_of[k] == 0) ? 1 : dwell_of[k]);
            end
            check_dut(k, eg, eb);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 4'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) check_dut(k, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [9:0]  dv [5] = '{10'd375, 10'h200, 10'h3FF, 10'd0, 10'd511};
    int          eh [5] = '{3, 5, 0, 0, 5};
    int          et [5] = '{7, 1, 0, 0, 1};
    int          eo [5] = '{5, 2, 1, 0, 1};
    int          en [5] = '{0, 1, 1, 0, 0};
    logic [39:0] rd;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        data  = '0;
        model_reset();
        do_reset();

        // Directed operands through requester 0, with explicit digit checks.
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, {30'b0, dv[i]});
            repeat (16) step(4'b0000, {30'b0, dv[i]});
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("dir%0d_neg_d%0d", i, k),  int'(neg[k]),  en[i]);
                check_eq($sformatf("dir%0d_hund_d%0d", i, k), int'(hund[k]), eh[i]);
                check_eq($sformatf("dir%0d_tens_d%0d", i, k), int'(tens[k]), et[i]);
                check_eq($sformatf("dir%0d_ones_d%0d", i, k), int'(ones[k]), eo[i]);
                check_eq($sformatf("dir%0d_src_d%0d", i, k),  int'(src[k]),  0);
            end
        end

        // All requesters held: rotation through the pointer.
        repeat (80) begin
            rd = {8'($urandom()), $urandom()};
            step(4'b1111, rd);
        end
        repeat (16) step(4'b0000, rd);

        // Operand change after the grant must not reach the display.
        step(4'b0010, {20'b0, 10'd100, 10'b0});
        step(4'b0000, {20'b0, 10'd100, 10'b0});
        step(4'b0000, {20'b0, 10'd100, 10'b0});
        repeat (16) step(4'b0000, {20'b0, 10'd999, 10'b0});
        check_eq("chg_hund", int'(hund[0]), 1);
        check_eq("chg_tens", int'(tens[0]), 0);
        check_eq("chg_ones", int'(ones[0]), 0);

        // Reset in the middle of a conversion, then pointer restart.
        step(4'b0001, {30'b0, 10'd123});
        repeat (4) step(4'b0000, {30'b0, 10'd123});
        do_reset();
        rd = {8'($urandom()), $urandom()};
        step(4'b0110, rd);
        repeat (16) step(4'b0000, rd);

        // DWELL=0 instance with a single held requester, then random traffic.
        repeat (40) step(4'b0100, {8'($urandom()), $urandom()});
        repeat (1500) begin
            rd = {8'($urandom()), $urandom()};
            step(4'($urandom_range(0, 15)), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
